uart_prot_rx: RTL and testbench
===============================

// Module: uart_prot_rx
// PURPOSE
//  UART receiver for the protocol-trigger path. Recovers 8N1 frames from the asynchronous RX
//  pin and emits each byte with a one-cycle valid strobe. Its outputs drive the protocol data
//  comparator directly (serial_data/serial_vld), so a trigger fires the cycle a matching byte lands.
// PARAMETERS
//  BAUD_W   16   width of baud_cnt (clocks per bit period)
// PORTS
//  clk          in   1       system clock; all logic on rising edge
//  rst          in   1       reset, synchronous, active-high
//  RX           in   1       asynchronous serial line, idle high, 8N1, LSB first
//  baud_cnt     in   BAUD_W  clocks per bit; legal range 4..2^BAUD_W-1
//  serial_data  out  8       last correctly framed byte received
//  serial_vld   out  1       one-cycle strobe: serial_data updated this cycle
//  frame_err    out  1       one-cycle strobe: stop bit sampled low, byte discarded
//  busy         out  1       high from start-edge detection until return to IDLE
// BEHAVIOUR
//  Reset (sync, active-high): serial_data=8'h00, serial_vld=0, frame_err=0, busy=0, state=IDLE.
//   Sync flops and edge flop preset to 1 (line idle), so no false start after reset.
//  Input: RX passes through 2 flops (rx_s), plus 1 history flop (rx_q).
//   Start edge = rx_q & ~rx_s.
//  Baud: down-counter bit_tmr; a sample event occurs when bit_tmr==0.
//   baud_cnt is latched into baud_q on start detection; changing baud_cnt mid-frame has no
//   effect on that frame.
//  FSM:
//   IDLE:  busy=0. On start edge: bit_tmr<=baud_cnt>>1 (half bit); go to START.
//   START: on sample, if rx_s==1 (glitch) go to IDLE with no strobe.
//          Else bit_tmr<=baud_q-1; bit_idx<=0; go to DATA.
//   DATA:  on sample, shift rx_s into shift reg MSB (right shift, LSB first);
//          bit_tmr<=baud_q-1; bit_idx++. After the 8th sample go to STOP.
//   STOP:  on sample, if rx_s==1: serial_data<=shift reg and serial_vld=1 for exactly one cycle.
//          If rx_s==0: frame_err=1 for one cycle and serial_data is held.
//          Either way go to IDLE.
//  All samples are at mid-bit (half-bit offset from the detected edge), counted as
//   bit_tmr reload value+1 clocks.
//  Latency: serial_vld rises 3 + (baud_cnt>>1) + 9*baud_cnt + 1 cycles (+/-1) after RX falls.
//  serial_vld and frame_err are never high in the same cycle.
//  serial_data is stable between strobes.
//  Back-to-back: IDLE is reached mid-stop-bit, so a start edge arriving immediately after
//   the stop bit is caught; a minimum 1-stop-bit gap is supported at any legal baud_cnt.
//  After frame_err the line may still be low (break): no new start until rx_s returns high
//   and falls again.
//  Reset mid-frame: aborts immediately, no strobe; the partial byte is discarded.
//  baud_cnt<4: behaviour undefined; not checked.
// TESTING  (baud_cnt=16 unless noted; frames driven by bench UART model)
//  1. Frame 0xA5, stop=1 -> serial_data=8'hA5, serial_vld high 1 cycle, frame_err=0, busy
//     drops after.
//  2. 0x00 then 0xFF back-to-back, 1 stop bit -> two vld strobes, 0x00 then 0xFF,
//     ~160 clocks apart.
//  3. RX low for 4 clocks then high (glitch < half bit) -> no strobes, busy returns 0,
//     next 0x3C received correctly.
//  4. Frame 0x3C with stop bit=0 -> frame_err 1 cycle, serial_vld=0, serial_data keeps
//     prior 0xA5.
//  5. rst asserted during data bit 3 of 0x5A -> all outputs reset values next cycle;
//     a fresh 0x5A frame is then received exactly.
//  6. baud_cnt=434, 0x7E; baud_cnt changed to 100 mid-frame -> 0x7E still received, no
//     frame_err. Chained into data_comp with match=0x7E, mask=0 -> prot_trig high exactly in
//     the vld cycle.

Source files
------------

// File: rtl/uart_prot_rx.sv
// 8N1 UART receiver feeding the protocol data comparator: mid-bit sampling from a
// synchronised RX line, one-cycle serial_vld / frame_err strobes, data held between bytes.
module uart_prot_rx #(
  parameter int BAUD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX,
  input  logic [BAUD_W-1:0] baud_cnt,
  output logic [7:0]        serial_data,
  output logic              serial_vld,
  output logic              frame_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [BAUD_W-1:0] TMR_ONE = BAUD_W'(1);

  state_t            state;
  logic              rx_m;
  logic              rx_s;
  logic              rx_q;
  logic [BAUD_W-1:0] bit_tmr;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_q;
  logic              start_edge;
  logic              sample;

  assign start_edge = rx_q & ~rx_s;
  assign sample     = (bit_tmr == '0);

  // NOTE: every register here is written with <= so all flops see the pre-edge
  // values of each other; blocking assignments would let the synchroniser
  // stages collapse into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchroniser and history preset high so an idle line never looks like a start edge.
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      rx_q        <= 1'b1;
      state       <= IDLE;
      bit_tmr     <= '0;
      baud_q      <= '0;
      bit_idx     <= '0;
      shift_q     <= '0;
      serial_data <= 8'h00;
      serial_vld  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_m       <= RX;
      rx_s       <= rx_m;
      rx_q       <= rx_s;
      serial_vld <= 1'b0;
      frame_err  <= 1'b0;

      if (state != IDLE && !sample) begin
        bit_tmr <= bit_tmr - TMR_ONE;
      end

      case (state)
        IDLE: begin
          if (start_edge) begin
            bit_tmr <= baud_cnt >> 1;
            baud_q  <= baud_cnt;
            busy    <= 1'b1;
            state   <= START;
          end
        end

        START: begin
          if (sample) begin
            if (rx_s) begin
              // Line already back high at mid start bit: treat as a glitch.
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              bit_tmr <= baud_q - TMR_ONE;
              bit_idx <= '0;
              state   <= DATA;
            end
          end
        end

        DATA: begin
          if (sample) begin
            shift_q <= {rx_s, shift_q[7:1]};
            bit_tmr <= baud_q - TMR_ONE;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end
        end

        STOP: begin
          if (sample) begin
            // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
            if (rx_s) begin
              serial_data <= shift_q;
              serial_vld  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prot_rx.sv
// Self-checking bench for uart_prot_rx: bench UART driver pushes expected strobes into a
// scoreboard queue, a negedge monitor pops and compares them against what the receiver emits.
module tb_uart_prot_rx;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         fall;
    int         baud;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] baud_cnt = 16'd16;
  logic [7:0]  serial_data;
  logic        serial_vld;
  logic        frame_err;
  logic        busy;

  logic [7:0]  match_val = 8'h7E;
  logic [7:0]  mask_val = 8'h00;
  logic        prot_trig;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_data = 8'h00;
  exp_t        exp_q[$];

  uart_prot_rx #(.BAUD_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (rx),
    .baud_cnt   (baud_cnt),
    .serial_data(serial_data),
    .serial_vld (serial_vld),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Downstream protocol data comparator: a set mask bit means "don't care".
  assign prot_trig = serial_vld & (((serial_data ^ match_val) & ~mask_val) == 8'h00);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic hold_line(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame, LSB first; chg != 0 changes baud_cnt partway through the data bits.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int b, input int chg);
    exp_t e;
    baud_cnt = 16'(b);
    e.err  = !stop_ok;
    e.data = d;
    e.fall = cyc;
    e.baud = b;
    exp_q.push_back(e);
    hold_line(1'b0, b);
    for (int i = 0; i < 8; i++) begin
      if (i == 4 && chg != 0) baud_cnt = 16'(chg);
      hold_line(d[i], b);
    end
    hold_line(stop_ok, b);
    rx = 1'b1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      check("vld_err_exclusive", {31'd0, serial_vld & frame_err}, 32'd0);
      if (serial_vld || frame_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got vld=%0b err=%0b data=%0h expected no strobe",
                   serial_vld, frame_err, serial_data);
        end else begin
          exp_t e;
          int   lat;
          int   want;
          e = exp_q.pop_front();
          check("strobe_kind", {30'd0, serial_vld, frame_err}, e.err ? 32'd1 : 32'd2);
          check("prot_trig", {31'd0, prot_trig},
                {31'd0, (!e.err && ((e.data ^ match_val) & ~mask_val) == 8'h00)});
          if (!e.err) begin
            exp_data = e.data;
            check("serial_data", {24'd0, serial_data}, {24'd0, exp_data});
            lat  = cyc - e.fall;
            want = 4 + (e.baud >> 1) + 9 * e.baud;
            checks++;
            if (lat < want - 1 || lat > want + 1) begin
              errors++;
              $display("FAIL latency: got %0d cycles expected %0d +/-1", lat, want);
            end
          end else begin
            check("data_held_on_err", {24'd0, serial_data}, {24'd0, exp_data});
          end
        end
      end else begin
        check("data_stable", {24'd0, serial_data}, {24'd0, exp_data});
        check("no_trig", {31'd0, prot_trig}, 32'd0);
      end
    end
  end

  initial begin
    int b;
    int gap;
    bit ok;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", {24'd0, serial_data}, 32'd0);
    check("rst_vld", {31'd0, serial_vld}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold_line(1'b1, 20);

    // Single good frame; busy must be low once the stop bit is over.
    send_frame(8'hA5, 1'b1, 16, 0);
    @(negedge clk);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    hold_line(1'b1, 10);

    // Back-to-back, one stop bit.
    send_frame(8'h00, 1'b1, 16, 0);
    send_frame(8'hFF, 1'b1, 16, 0);
    hold_line(1'b1, 20);

    // Short glitch: no strobe expected, receiver returns idle.
    hold_line(1'b0, 4);
    hold_line(1'b1, 30);
    check("busy_after_glitch", {31'd0, busy}, 32'd0);
    send_frame(8'h3C, 1'b1, 16, 0);
    hold_line(1'b1, 20);

    // Framing error: data from the prior good frame must be held.
    send_frame(8'hA5, 1'b1, 16, 0);
    hold_line(1'b1, 5);
    send_frame(8'h3C, 1'b0, 16, 0);
    hold_line(1'b1, 20);

    // Reset during data bit 3 of 0x5A, then a clean 0x5A.
    baud_cnt = 16'd16;
    hold_line(1'b0, 16);
    for (int i = 0; i < 3; i++) hold_line(i[0] ? 1'b1 : 1'b0, 16);
    hold_line(1'b1, 8);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_data = 8'h00;
    check("midrst_data", {24'd0, serial_data}, 32'd0);
    check("midrst_vld", {31'd0, serial_vld}, 32'd0);
    check("midrst_err", {31'd0, frame_err}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold_line(1'b1, 20);
    send_frame(8'h5A, 1'b1, 16, 0);
    hold_line(1'b1, 20);

    // Slow baud with baud_cnt changed mid-frame; comparator matches 0x7E.
    send_frame(8'h7E, 1'b1, 434, 100);
    hold_line(1'b1, 50);

    // Randomised frames, bauds and gaps.
    for (int n = 0; n < 24; n++) begin
      b   = $urandom_range(16, 48);
      ok  = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, b);
      send_frame(8'($urandom_range(0, 255)), ok, b, 0);
      if (!ok && gap < 2) gap = 2;
      if (gap > 0) hold_line(1'b1, gap);
    end
    hold_line(1'b1, 20);

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 2000 && exp_q.size() != 0; w++) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
